// File: rtl/bounceback_pkg.sv
// Shared definitions for the bounceback pulse generator: register map,
// FSM state encoding and default counter width.
package bounceback_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    localparam logic [2:0] ADDR_LEVEL = 3'd0;
    localparam logic [2:0] ADDR_DELAY = 3'd1;
    localparam logic [2:0] ADDR_WIDTH = 3'd2;
    localparam logic [2:0] ADDR_CTRL  = 3'd3;
    localparam logic [2:0] ADDR_MASK  = 3'd4;
    localparam logic [2:0] ADDR_DONE  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_e;

endpackage

// File: rtl/bounceback_downcnt.sv
// Loadable down-counter; load takes priority over decrement, saturates at zero.
module bounceback_downcnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/bounceback_pulse_out.sv
// Avalon-MM slave that emits one delayed, programmable-width pulse per start
// command, with abort, manual level control and a maskable completion irq.
module bounceback_pulse_out
    import bounceback_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        out_port,
    output logic        irq
);

    state_e           state_q, state_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             mask_q, mask_d;
    logic             done_q, done_d;
    logic [15:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done_set;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] width_eff;
    logic             cnt_is_one;

    assign wr_en     = chipselect && !write_n;
    assign start     = wr_en && (address == ADDR_CTRL) && writedata[0];
    assign abort     = wr_en && (address == ADDR_CTRL) && writedata[1];
    assign busy      = (state_q != IDLE);
    assign width_eff = (width_q == '0) ? CNT_W'(1) : width_q;

    bounceback_downcnt #(
        .CNT_W (CNT_W)
    ) u_downcnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .is_one_o   (cnt_is_one)
    );

    // out_port is registered alongside the state, so it is high exactly in PULSE
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = width_eff;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cnt_load = 1'b1;
                    if (delay_q == '0) begin
                        state_d = PULSE;
                        out_d   = 1'b1;
                    end else begin
                        state_d = DELAY;
                        cnt_val = delay_q;
                        out_d   = 1'b0;
                    end
                end else if (wr_en && (address == ADDR_LEVEL)) begin
                    out_d = writedata[0];
                end
            end
            DELAY: begin
                if (abort) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end else if (cnt_is_one) begin
                    state_d  = PULSE;
                    out_d    = 1'b1;
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            PULSE: begin
                if (abort) begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                end else if (cnt_is_one) begin
                    state_d  = IDLE;
                    out_d    = 1'b0;
                    done_set = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        delay_d = delay_q;
        width_d = width_q;
        mask_d  = mask_q;
        done_d  = done_q;
        if (wr_en) begin
            case (address)
                ADDR_DELAY: delay_d = CNT_W'(writedata);
                ADDR_WIDTH: width_d = CNT_W'(writedata);
                ADDR_MASK:  mask_d  = writedata[0];
                ADDR_DONE:  done_d  = 1'b0;
                default:    ;
            endcase
        end
        // completion beats a simultaneous clear
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_LEVEL: readdata_d = {15'b0, out_q};
            ADDR_DELAY: readdata_d = 16'(delay_q);
            ADDR_WIDTH: readdata_d = 16'(width_q);
            ADDR_CTRL:  readdata_d = {15'b0, busy};
            ADDR_MASK:  readdata_d = {15'b0, mask_q};
            ADDR_DONE:  readdata_d = {15'b0, done_q};
            default:    readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            out_q      <= 1'b0;
            delay_q    <= '0;
            width_q    <= '0;
            mask_q     <= 1'b0;
            done_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            delay_q    <= delay_d;
            width_q    <= width_d;
            mask_q     <= mask_d;
            done_q     <= done_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_q;
    assign irq      = done_q & mask_q;

endmodule

// File: doc/bounceback_pulse_out.md
BOUNCEBACK_PULSE_OUT -- requirements
Module: bounceback_pulse_out

Interface
REQ-001 SHALL have ports: clk input 1 (system clock); reset_n input 1 (reset, asynchronous, active-low).
REQ-002 SHALL have port address input 3, Avalon-MM slave register select.
REQ-003 SHALL have port chipselect input 1, slave select.
REQ-004 SHALL have port write_n input 1, active-low write strobe.
REQ-005 SHALL have port writedata input 16, write data.
REQ-006 SHALL have port readdata output 16, registered read data.
REQ-007 SHALL have port out_port output 1, registered bounceback pulse output pin.
REQ-008 SHALL have port irq output 1, completion interrupt.
REQ-009 Parameter CNT_W SHALL default to 16 and set the delay and width counter size.

Function
REQ-010 Write strobe SHALL be chipselect && ~write_n; zero wait states.
REQ-011 Register map SHALL be:
- 0: manual level. Bit0 read = out_port; write sets out_port only in IDLE, ignored otherwise.
- 1: delay[15:0], RW.
- 2: width[15:0], RW.
- 3: control. Write bit0 = start, bit1 = abort; read bit0 = busy.
- 4: irq_mask bit0, RW.
- 5: done flag bit0. Read returns the flag; any write clears it.
- 6, 7: read 0, writes ignored.
REQ-012 readdata SHALL register the read mux every clk, one-cycle latency, unused bits 0.
REQ-013 FSM states SHALL be IDLE, DELAY, PULSE.
REQ-014 Start in IDLE:
- delay==0: go to PULSE, load counter with max(width,1).
- else: go to DELAY, load counter with delay.
REQ-015 DELAY SHALL decrement each cycle; at count 1 go to PULSE and load max(width,1).
REQ-016 out_port SHALL be 1 exactly while in PULSE.
- Start written at edge N: first high cycle follows edge N+1+delay; duration max(width,1) cycles.
REQ-017 PULSE SHALL decrement each cycle; at count 1 go to IDLE, drive out_port 0, set done the same edge.
REQ-018 Start while busy (DELAY or PULSE) SHALL be ignored.
REQ-019 Abort SHALL force IDLE and out_port 0 next edge; done not set. Abort wins over start in the same write.
REQ-020 Delay and width writes during busy SHALL be stored; they take effect at the next start only.
REQ-021 Done set and done clear on the same edge: set SHALL win.
REQ-022 irq SHALL equal done & irq_mask, combinational from registers.
REQ-023 busy SHALL be 1 in DELAY or PULSE.

Reset
REQ-024 Reset SHALL set: state IDLE; out_port 0; readdata 0; delay 0; width 0; counter 0; irq_mask 0; done 0; irq 0.
REQ-025 Reset mid-pulse SHALL drop out_port to 0 immediately (asynchronous). No done is generated after release.

Structure
REQ-026 Shared package bounceback_pkg SHALL hold the register address constants (ADDR_LEVEL..ADDR_DONE), the FSM state enum, and CNT_W default.
REQ-027 One sub-module, bounceback_downcnt, SHALL provide the loadable down-counter with an is_one flag. Everything else stays in the top.

Verification
REQ-028 delay=3, width=5, start at edge N -> out_port high edges N+4..N+8, low at N+9, done=1 at N+9; irq stays 0 with mask 0.
REQ-029 delay=0, width=0, irq_mask=1, start -> one-cycle pulse at N+1; irq=1 from N+2 until a write to addr 5 clears it.
REQ-030 delay=10, width=4; start, then abort at N+5 -> out_port never high; busy 0 at N+6; done stays 0; second start ignored while busy before abort.
REQ-031 During PULSE, width written to 2 and level written to 1 -> current pulse unchanged; level write ignored; next start uses width 2.
REQ-032 Done-clear write on the completion edge -> done=1 after the edge; readdata for addr 5 = 0x0001 one cycle after the read.
REQ-033 reset_n asserted mid-PULSE -> out_port 0 without waiting for clk; all registers reset values; no irq after release.
